imem_loader: RTL and testbench

Byte-stream program loader that fills the CPU's 16-word instruction memory before execution. It accepts a framed byte stream (length, big-endian instruction words, XOR checksum) over a valid/ready handshake. It writes each assembled 16-bit word into the instruction memory write port. It holds the CPU in reset until a frame loads with a correct checksum.

---
 rtl/imem_loader_if.sv | 10 +
 rtl/imem_loader.sv | 142 ++++++++++++++
 tb/tb_imem_loader.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream handshake between a program source and the instruction memory loader.
// The source drives valid/data and the loader answers with ready.
interface imem_loader_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/imem_loader.sv
// Program loader: receives a framed byte stream (length, big-endian 16-bit words,
// XOR checksum), writes each word into the instruction memory and keeps the CPU
// in reset until a frame with a matching checksum has been loaded.
module imem_loader #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    imem_loader_if.slave      in_if,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data,
    output logic              cpu_reset,
    output logic              done,
    output logic              err
);

    localparam logic [7:0] MAX_LEN = 8'(DEPTH);

    typedef enum logic [2:0] {
        S_LEN,
        S_HI,
        S_LO,
        S_CSUM,
        S_DONE,
        S_ERROR
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W:0]   len;
    logic [ADDR_W:0]   count;
    logic [ADDR_W:0]   count_inc;
    logic [7:0]        csum;
    logic [7:0]        hi_byte;
    logic              ready;
    logic              accept;

    // The loader takes bytes in every frame-parsing state; DONE and ERROR are terminal.
    assign ready          = (state == S_LEN) || (state == S_HI) ||
                            (state == S_LO)  || (state == S_CSUM);
    assign in_if.in_ready = ready;
    assign accept         = in_if.in_valid && ready;
    assign count_inc      = count + 1'b1;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values and the simulation order cannot leak in.
        if (reset) begin
            state <= S_LEN;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode: advances only on an accepted byte.
    always_comb begin
        // NOTE: default first, so every path assigns state_next and no latch is inferred.
        state_next = state;
        case (state)
            S_LEN: begin
                if (accept) begin
                    if (in_if.in_data == 8'd0 || in_if.in_data > MAX_LEN) begin
                        state_next = S_ERROR;
                    end else begin
                        state_next = S_HI;
                    end
                end
            end
            S_HI: begin
                if (accept) begin
                    state_next = S_LO;
                end
            end
            S_LO: begin
                if (accept) begin
                    state_next = (count_inc == len) ? S_CSUM : S_HI;
                end
            end
            S_CSUM: begin
                if (accept) begin
                    state_next = (in_if.in_data == csum) ? S_DONE : S_ERROR;
                end
            end
            S_DONE:  state_next = S_DONE;
            S_ERROR: state_next = S_ERROR;
            default: state_next = S_ERROR;
        endcase
    end

    // Datapath: length, checksum, word assembly, write strobe and sticky status.
    always_ff @(posedge clk) begin
        if (reset) begin
            len       <= '0;
            count     <= '0;
            csum      <= '0;
            hi_byte   <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            cpu_reset <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            if (accept) begin
                case (state)
                    S_LEN: begin
                        if (state_next == S_HI) begin
                            len     <= in_if.in_data[ADDR_W:0];
                            csum    <= in_if.in_data;
                            count   <= '0;
                            wr_addr <= '0;
                        end
                    end
                    S_HI: begin
                        hi_byte <= in_if.in_data;
                        csum    <= csum ^ in_if.in_data;
                    end
                    S_LO: begin
                        csum    <= csum ^ in_if.in_data;
                        wr_en   <= 1'b1;
                        wr_addr <= count[ADDR_W-1:0];
                        wr_data <= {hi_byte, in_if.in_data};
                        count   <= count_inc;
                    end
                    default: ;
                endcase
            end
            if (state_next == S_DONE) begin
                done      <= 1'b1;
                cpu_reset <= 1'b0;
            end
            if (state_next == S_ERROR) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed frame table, hand-written
// mid-frame reset sequence, and randomized frames checked against a frame-level model.
module tb_imem_loader;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [15:0]       wr_data;
    logic              cpu_reset;
    logic              done;
    logic              err;

    imem_loader_if bus ();

    imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_if     (bus),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .cpu_reset (cpu_reset),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [15:0]       data;
    } wr_t;

    typedef struct packed {
        logic [2:0] kind;      // 0 nominal, 1 bad checksum, 2 length 0, 3 length 17, 4 full depth
        logic [7:0] stall;     // idle cycles between bytes
        logic       exp_done;
        logic       exp_err;
        logic [7:0] exp_nwr;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    byte unsigned frame[$];
    wr_t          got[$];
    wr_t          exp_wr[$];
    bit           m_done;
    bit           m_err;
    logic         prev_wr = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Write-port monitor: records every strobe and checks strobes never touch.
    always @(negedge clk) begin
        if (wr_en) begin
            got.push_back(wr_t'{wr_addr, wr_data});
            check("wr_en_gap", 32'(prev_wr), 0);
        end
        prev_wr = wr_en;
    end

    // Frame-level reference: what a correct loader must write and how it must end.
    function automatic void model();
        int n;
        byte unsigned c;
        exp_wr.delete();
        m_done = 1'b0;
        m_err  = 1'b0;
        n = frame[0];
        if (n == 0 || n > DEPTH) begin
            m_err = 1'b1;
            return;
        end
        c = 8'h00;
        for (int i = 0; i <= 2 * n; i++) c ^= frame[i];
        for (int w = 0; w < n; w++)
            exp_wr.push_back(wr_t'{4'(w), {frame[1 + 2 * w], frame[2 + 2 * w]}});
        if (frame[2 * n + 1] == c) m_done = 1'b1;
        else                       m_err  = 1'b1;
    endfunction

    task automatic build(input int kind);
        case (kind)
            0: frame = '{8'h04, 8'h21, 8'h05, 8'h22, 8'h06, 8'h03, 8'h12, 8'h14, 8'h12, 8'h13};
            1: frame = '{8'h04, 8'h21, 8'h05, 8'h22, 8'h06, 8'h03, 8'h12, 8'h14, 8'h12, 8'h12};
            2: frame = '{8'h00, 8'h21, 8'h05};
            3: frame = '{8'h11, 8'h21, 8'h05};
            default: begin
                frame = '{8'h10};
                for (int i = 0; i < 16; i++) begin
                    frame.push_back(8'h00);
                    frame.push_back(8'(i));
                end
                frame.push_back(8'h10);   // 0x10 ^ (0 ^ 1 ^ ... ^ 15) = 0x10
            end
        endcase
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        got.delete();
        check("rst_in_ready",  32'(bus.in_ready), 1);
        check("rst_cpu_reset", 32'(cpu_reset), 1);
        check("rst_done",      32'(done), 0);
        check("rst_err",       32'(err), 0);
    endtask

    // Sends up to max_bytes of frame; gives up (holding valid a while) once ready drops.
    // Returns just after the rising edge that took the last accepted byte.
    task automatic send_frame(input int stall, input int max_bytes);
        for (int i = 0; i < frame.size() && i < max_bytes; i++) begin
            if (i > 0) begin
                repeat (stall) begin
                    @(negedge clk);
                    bus.in_valid = 1'b0;
                    bus.in_data  = 8'($urandom);
                end
            end
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data  = frame[i];
            if (!bus.in_ready) begin
                repeat (3) @(negedge clk);
                bus.in_valid = 1'b0;
                return;
            end
            @(posedge clk);
        end
    endtask

    task automatic finish_check(input string tag, input bit exp_done, input bit exp_err);
        int n;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check({tag, "_done"},      32'(done), 32'(exp_done));
        check({tag, "_err"},       32'(err), 32'(exp_err));
        check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'(!exp_done));
        check({tag, "_in_ready"},  32'(bus.in_ready), 0);
        check({tag, "_nwr"},       32'(got.size()), 32'(exp_wr.size()));
        n = (got.size() < exp_wr.size()) ? got.size() : exp_wr.size();
        for (int i = 0; i < n; i++) begin
            check({tag, "_addr"}, 32'(got[i].addr), 32'(exp_wr[i].addr));
            check({tag, "_data"}, 32'(got[i].data), 32'(exp_wr[i].data));
        end
        if (exp_wr.size() > 0)
            check({tag, "_addr_hold"}, 32'(wr_addr), 32'(exp_wr[exp_wr.size() - 1].addr));
    endtask

    vec_t tbl[6];

    initial begin
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;

        tbl[0] = '{3'd0, 8'd0, 1'b1, 1'b0, 8'd4};   // nominal back-to-back
        tbl[1] = '{3'd0, 8'd3, 1'b1, 1'b0, 8'd4};   // nominal with 3-cycle stalls
        tbl[2] = '{3'd1, 8'd0, 1'b0, 1'b1, 8'd4};   // checksum mismatch
        tbl[3] = '{3'd2, 8'd0, 1'b0, 1'b1, 8'd0};   // length 0
        tbl[4] = '{3'd3, 8'd0, 1'b0, 1'b1, 8'd0};   // length 17
        tbl[5] = '{3'd4, 8'd1, 1'b1, 1'b0, 8'd16};  // full depth

        // Reset values straight out of reset.
        do_reset();
        check("rst_wr_en",   32'(wr_en), 0);
        check("rst_wr_addr", 32'(wr_addr), 0);
        check("rst_wr_data", 32'(wr_data), 0);

        // Directed frame table.
        for (int t = 0; t < 6; t++) begin
            do_reset();
            build(int'(tbl[t].kind));
            model();
            send_frame(int'(tbl[t].stall), frame.size());
            finish_check($sformatf("vec%0d", t), tbl[t].exp_done, tbl[t].exp_err);
            check($sformatf("vec%0d_nwr_tbl", t), 32'(got.size()), 32'(tbl[t].exp_nwr));
        end

        // Nominal words spelled out.
        do_reset();
        build(0);
        send_frame(0, frame.size());
        @(negedge clk);
        check("nom_nwr", 32'(got.size()), 4);
        if (got.size() == 4) begin
            check("nom_w0", 32'(got[0].data), 32'h2105);
            check("nom_w1", 32'(got[1].data), 32'h2206);
            check("nom_w2", 32'(got[2].data), 32'h0312);
            check("nom_w3", 32'(got[3].data), 32'h1412);
            check("nom_a3", 32'(got[3].addr), 3);
        end

        // Reset mid-frame after 04,21,05,22, then a clean nominal frame.
        do_reset();
        build(0);
        send_frame(0, 4);
        @(negedge clk);
        bus.in_valid = 1'b0;
        reset        = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_cpu_reset", 32'(cpu_reset), 1);
        check("mid_in_ready",  32'(bus.in_ready), 1);
        check("mid_nwr",       32'(got.size()), 1);
        if (got.size() > 0) begin
            check("mid_addr0", 32'(got[0].addr), 0);
            check("mid_data0", 32'(got[0].data), 32'h2105);
        end
        got.delete();
        model();
        send_frame(0, frame.size());
        finish_check("mid_reload", 1'b1, 1'b0);

        // Randomized frames against the reference model.
        for (int r = 0; r < 24; r++) begin
            int n;
            byte unsigned c;
            do_reset();
            if ($urandom_range(0, 7) == 0) begin
                n = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(17, 255);
                frame = '{8'(n), 8'($urandom), 8'($urandom)};
            end else begin
                n = $urandom_range(1, DEPTH);
                frame = '{8'(n)};
                c = 8'(n);
                for (int i = 0; i < 2 * n; i++) begin
                    frame.push_back(8'($urandom));
                    c ^= frame[frame.size() - 1];
                end
                if ($urandom_range(0, 3) == 0) c ^= 8'($urandom_range(1, 255));
                frame.push_back(c);
            end
            model();
            send_frame($urandom_range(0, 2), frame.size());
            finish_check($sformatf("rnd%0d", r), m_done, m_err);
        end

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
